// File: rtl/uart_tx_framer.sv
// -----------------------------------------------------------------------------
// uart_tx_framer
//
// Serialises one parallel word per request into a UART frame. Bits leave LSB
// first, with optional parity. clk runs at the baud rate, so each state cycle
// is one bit time on the line.
//
// Frame: START(0) | DATA_WIDTH data bits | [PARITY] | STOP(1)
//
// Configuration:
//   UART_TX_PARITY_EN  defined   : par_en/par_typ select an even or odd parity
//                                  bit for each frame.
//                      undefined : the PARITY state and all parity logic are
//                                  compiled out. par_en/par_typ stay as ports
//                                  but are ignored.
//
// Ports:
//   clk         transmit (baud) clock
//   rst_n       asynchronous active-low reset
//   p_data      parallel payload, DATA_WIDTH bits
//   data_valid  request to send p_data; honoured only in IDLE or STOP
//   par_en      1 = append a parity bit
//   par_typ     0 = even parity, 1 = odd parity
//   tx_out      serial line, idle high (registered)
//   busy        high while a frame is on the line (registered)
// -----------------------------------------------------------------------------
module uart_tx_framer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    load;
  logic                    tx_d;
  logic                    busy_d;

`ifdef UART_TX_PARITY_EN
  logic                    par_en_q;
  logic                    par_typ_q;
`else
  // The parity controls are part of the port list in every build.
  logic                    unused_par;
  assign unused_par = par_en ^ par_typ;
`endif

  // Next-state logic. tx_out and busy are decoded from the *next* state and
  // registered, so the line shows the start bit in the cycle right after the
  // accepting edge.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (data_valid) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == LAST_BIT) begin
          cnt_d = '0;
`ifdef UART_TX_PARITY_EN
          state_d = par_en_q ? PARITY : STOP;
`else
          state_d = STOP;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: state_d = STOP;
`endif
      STOP: begin
        // Back-to-back: a request seen in the last stop cycle starts the
        // next frame without an idle bit in between.
        if (data_valid) begin
          load    = 1'b1;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    tx_d   = 1'b1;
    case (state_d)
      START:  tx_d = 1'b0;
      // data_q was loaded when START was entered, so it is stable here.
      DATA:   tx_d = data_q[cnt_d];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = (^data_q) ^ par_typ_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data and parity holding registers are reset too, so the
      // block leaves reset in a fully known state.
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from the
      // values that were present before this edge.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_out  <= tx_d;
      busy    <= busy_d;
      if (load) begin
        data_q    <= p_data;
`ifdef UART_TX_PARITY_EN
        par_en_q  <= par_en;
        par_typ_q <= par_typ;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_framer
//
// Self-checking bench for uart_tx_framer. A frame-level model keeps a queue of
// line bits that are still due. A frame is appended whenever the line is
// free at an edge and data_valid is high. Every cycle at the falling edge,
// tx_out and busy are compared with the head of the queue. Directed cases pin
// literal waveforms. A randomized phase then exercises the model.
// -----------------------------------------------------------------------------
module tb_uart_tx_framer;

  localparam int W = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FL_P = W + 3;
`else
  localparam int FL_P = W + 2;
`endif
  localparam int FL = W + 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] p_data;
  logic         data_valid;
  logic         par_en;
  logic         par_typ;
  logic         tx_out;
  logic         busy;

  int checks = 0;
  int errors = 0;

  bit exp_q[$];

  uart_tx_framer #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: the queue holds the bits still due on the line. An empty
  // queue means the line is free (idle, or the stop bit just finished).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (exp_q.size() == 0 && data_valid) begin
        exp_q.push_back(1'b0);
        for (int i = 0; i < W; i++) exp_q.push_back(p_data[i]);
`ifdef UART_TX_PARITY_EN
        if (par_en) exp_q.push_back((^p_data) ^ par_typ);
`endif
        exp_q.push_back(1'b1);
      end
    end
  end

  // Compare process: runs every cycle against the model.
  always @(negedge clk) begin
    check("model_tx_out", 32'(tx_out), 32'((exp_q.size() > 0) ? exp_q[0] : 1'b1));
    check("model_busy",   32'(busy),   32'(exp_q.size() > 0));
  end

  // Request one word: raise data_valid for exactly one rising edge. Returns at
  // the falling edge where the start bit is on the line.
  task automatic send(input logic [W-1:0] d, input logic pe, input logic pt);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  // Record n line bits, the first in the MSB, and AND together busy over
  // those n cycles. Returns one cycle after the last bit.
  task automatic capture(input int n, output logic [31:0] cap, output logic all_busy);
    cap      = '0;
    all_busy = 1'b1;
    for (int i = 0; i < n; i++) begin
      cap      = {cap[30:0], tx_out};
      all_busy = all_busy & busy;
      @(negedge clk);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_tx"},   32'(tx_out), 32'(1));
    check({name, "_busy"}, 32'(busy),   32'(0));
  endtask

  logic [31:0] cap;
  logic        all_b;

  initial begin
    rst_n      = 1'b0;
    p_data     = '0;
    data_valid = 1'b0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("post_reset");

    // 0xA5 without parity: start, LSB-first data, stop.
    send(8'hA5, 1'b0, 1'b0);
    capture(FL, cap, all_b);
    check("a5_nopar_wave", cap, 32'b0101001011);
    check("a5_nopar_busy", 32'(all_b), 32'(1));
    check_idle("a5_nopar_end");
    repeat (2) @(negedge clk);

`ifdef UART_TX_PARITY_EN
    // 0xA5 has four ones, so even parity gives 0 and odd parity gives 1.
    send(8'hA5, 1'b1, 1'b0);
    capture(W + 3, cap, all_b);
    check("a5_even_wave", cap, 32'b01010010101);
    check("a5_even_busy", 32'(all_b), 32'(1));
    check_idle("a5_even_end");
    send(8'hA5, 1'b1, 1'b1);
    capture(W + 3, cap, all_b);
    check("a5_odd_wave", cap, 32'b01010010111);
    check_idle("a5_odd_end");
`else
    // Parity compiled out: par_en has no effect on the frame.
    send(8'hA5, 1'b1, 1'b0);
    capture(FL, cap, all_b);
    check("a5_parignored_wave", cap, 32'b0101001011);
    check("a5_parignored_busy", 32'(all_b), 32'(1));
    check_idle("a5_parignored_end");
`endif
    repeat (2) @(negedge clk);

    // Back-to-back: 0xFF is requested while the stop bit of 0x00 is on the line.
    send(8'h00, 1'b0, 1'b0);
    cap   = '0;
    all_b = 1'b1;
    for (int i = 0; i < 2 * FL; i++) begin
      cap   = {cap[30:0], tx_out};
      all_b = all_b & busy;
      if (i == FL - 1) begin
        p_data     = 8'hFF;
        data_valid = 1'b1;
      end else begin
        data_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b_wave", cap, 32'b0000000001_0111111111);
    check("b2b_busy", 32'(all_b), 32'(1));
    check_idle("b2b_end");
    repeat (2) @(negedge clk);

    // A request during DATA and a par_typ toggle mid-frame: both are ignored.
    send(8'h81, 1'b1, 1'b0);
    cap = '0;
    for (int i = 0; i < FL_P; i++) begin
      cap = {cap[30:0], tx_out};
      if (i == 4) begin
        p_data     = 8'h3C;
        data_valid = 1'b1;
        par_typ    = 1'b1;
      end else begin
        data_valid = 1'b0;
      end
      @(negedge clk);
    end
`ifdef UART_TX_PARITY_EN
    check("ignore_wave", cap, 32'b01000000101);
`else
    check("ignore_wave", cap, 32'b0100000011);
`endif
    check_idle("ignore_end");
    repeat (3) @(negedge clk);
    check_idle("ignore_stays_idle");

    // Reset while data bit 4 of 0x55 is on the line.
    send(8'h55, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check("rst_pre_tx",   32'(tx_out), 32'(1));
    check("rst_pre_busy", 32'(busy),   32'(1));
    #2 rst_n = 1'b0;
    #1;
    check_idle("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_idle("rst_release");

    // Randomized traffic checked by the model.
    repeat (400) begin
      @(negedge clk);
      data_valid = ($urandom_range(0, 3) == 0);
      p_data     = W'($urandom);
      par_en     = 1'($urandom);
      par_typ    = 1'($urandom);
    end
    data_valid = 1'b0;
    repeat (FL_P + 3) @(negedge clk);
    check_idle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, number of payload bits per frame (legal range 5..9).
REQ-002 clk  input  1  transmit clock; one serial bit is emitted per clk cycle (clk runs at the baud rate).
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 p_data  input  DATA_WIDTH  parallel payload to transmit.
REQ-005 data_valid  input  1  request: p_data is valid and should be sent.
REQ-006 par_en  input  1  1 = append parity bit to the frame.
REQ-007 par_typ  input  1  parity type: 0 = even, 1 = odd.
REQ-008 tx_out  output  1  serial line, idle high.
REQ-009 busy  output  1  high while a frame is on the line.

Function
REQ-010 The block SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-011 tx_out and busy SHALL be registered outputs driven directly from flops.
REQ-012 In IDLE: tx_out=1, busy=0.
REQ-013 In IDLE, data_valid=1 at edge k SHALL latch p_data, par_en and par_typ, and enter START.
REQ-014 START SHALL drive tx_out=0 and busy=1 during cycle k+1, i.e. one-cycle latency from acceptance.
REQ-015 DATA SHALL last exactly DATA_WIDTH cycles and emit the latched data LSB first.
REQ-016 A bit counter SHALL count 0..DATA_WIDTH-1 and clear when DATA is left.
REQ-017 After DATA, the FSM SHALL enter PARITY when latched par_en=1, otherwise STOP.
REQ-018 The PARITY bit SHALL equal the XOR of the latched data when par_typ=0 (even), and its inverse when par_typ=1 (odd); PARITY lasts one cycle.
REQ-019 STOP SHALL drive tx_out=1 and busy=1 for one cycle.
REQ-020 Frame length SHALL be DATA_WIDTH+2 cycles, or DATA_WIDTH+3 cycles with parity.
REQ-021 At the end of STOP, data_valid=1 SHALL accept a new word and go directly to START (back-to-back, no idle cycle); otherwise the FSM returns to IDLE.
REQ-022 data_valid in START, DATA or PARITY SHALL be ignored, and the request is not queued.
REQ-023 Changes to p_data, par_en or par_typ after acceptance SHALL NOT affect the frame in flight.
REQ-024 busy SHALL be 1 in every non-IDLE state and 0 in IDLE.

Reset
REQ-025 When rst_n=0, the block SHALL asynchronously force state=IDLE, tx_out=1, busy=0, bit counter=0 and the data/parity latches=0.
REQ-026 A reset asserted mid-frame SHALL abort the frame immediately with tx_out=1 and no partial stop bit; the first edge after release stays in IDLE unless data_valid=1.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: parity is supported per REQ-017/018.
REQ-028 Macro UART_TX_PARITY_EN undefined: the PARITY state and parity logic are compiled out, par_en/par_typ remain as ports but are ignored, and every frame is DATA_WIDTH+2 cycles.

Verification
REQ-029 Send p_data=0xA5 with par_en=0 -> tx_out = 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop) over 10 cycles, and busy=1 throughout.
REQ-030 Send 0xA5 with par_en=1, par_typ=0 -> parity bit 0, 11-cycle frame; repeat with par_typ=1 -> parity bit 1.
REQ-031 Send 0x00, then hold data_valid=1 with 0xFF presented in the STOP cycle -> the stop bit is immediately followed by the start bit of 0xFF, and busy never drops.
REQ-032 Pulse data_valid with 0x3C during DATA of frame 0x81, and toggle par_typ mid-frame -> the 0x81 frame is unaltered, 0x3C is never sent, and the line returns to IDLE.
REQ-033 Assert rst_n=0 during data bit 4 of 0x55 -> tx_out=1 and busy=0 at once with no clock edge needed; after release with data_valid=0 the line stays high.
REQ-034 Build without UART_TX_PARITY_EN, send 0xA5 with par_en=1 -> same 10-cycle waveform as REQ-029.
